alu_op_sequencer: RTL and testbench

- Initiator side of the multi-cycle ALU (`au`) interface.
- Accepts 2-bit operation requests (a, b, ctrl) on a valid/ready input and buffers them in a small FIFO.
- Issues each request to the ALU with a one-cycle start pulse, waits for done, then captures y/c.
- Returns each result on a valid/ready output, with an error flag for divide-by-zero and ALU timeout.

---
 rtl/alu_op_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Initiator for a multi-cycle ALU: buffers 2-bit op requests, issues one at a time,
// returns results with a div-by-zero/timeout error flag. Optional: ALU_SEQ_STATS_EN adds stat counters.
module alu_op_sequencer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:0] in_a,
   input  logic [1:0] in_b,
   input  logic [1:0] in_ctrl,
   output logic [1:0] alu_a,
   output logic [1:0] alu_b,
   output logic [1:0] alu_ctrl,
   output logic       alu_start,
   input  logic [3:0] alu_y,
   input  logic       alu_c,
   input  logic       alu_done,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_y,
   output logic       out_c,
   output logic       out_err,
   output logic [1:0] out_ctrl,
   output logic       busy
`ifdef ALU_SEQ_STATS_EN
   ,
   output logic [7:0] stat_ops,
   output logic [7:0] stat_errs
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   logic [5:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   state_t        r_state;
   logic [7:0]    r_tcnt;
   logic          r_alu_start;
   logic [1:0]    r_alu_a;
   logic [1:0]    r_alu_b;
   logic [1:0]    r_alu_ctrl;
   logic          r_out_valid;
   logic [3:0]    r_out_y;
   logic          r_out_c;
   logic          r_out_err;
   logic [1:0]    r_out_ctrl;

   logic          w_push;
   logic          w_pop;
   logic [5:0]    w_head;
   logic          w_div0;
   logic [7:0]    w_tcnt_inc;

   assign in_ready   = (r_count != CW'(DEPTH));
   assign w_push     = in_valid & in_ready;
   assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
   assign w_head     = r_mem[r_rd_ptr];
   assign w_div0     = (w_head[1:0] == 2'b11) && (w_head[3:2] == 2'b00);
   assign w_tcnt_inc = r_tcnt + 8'd1;

   // Entry layout: {a, b, ctrl}
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {in_a, in_b, in_ctrl};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // alu_start is raised on entry to ISSUE so it is high for exactly the ISSUE cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_tcnt      <= '0;
         r_alu_start <= 1'b0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_ctrl  <= '0;
         r_out_valid <= 1'b0;
         r_out_y     <= '0;
         r_out_c     <= 1'b0;
         r_out_err   <= 1'b0;
         r_out_ctrl  <= '0;
      end else begin
         r_alu_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  if (w_div0) begin
                     r_out_y     <= '0;
                     r_out_c     <= 1'b0;
                     r_out_err   <= 1'b1;
                     r_out_ctrl  <= w_head[1:0];
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_alu_a     <= w_head[5:4];
                     r_alu_b     <= w_head[3:2];
                     r_alu_ctrl  <= w_head[1:0];
                     r_alu_start <= 1'b1;
                     r_state     <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               r_tcnt  <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               // A done arriving on the final allowed cycle still wins over the timeout.
               if (alu_done) begin
                  r_out_y     <= alu_y;
                  r_out_c     <= alu_c;
                  r_out_err   <= 1'b0;
                  r_out_ctrl  <= r_alu_ctrl;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_tcnt <= w_tcnt_inc;
                  if (w_tcnt_inc == 8'(TIMEOUT)) begin
                     r_out_y     <= '0;
                     r_out_c     <= 1'b0;
                     r_out_err   <= 1'b1;
                     r_out_ctrl  <= r_alu_ctrl;
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign alu_start = r_alu_start;
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_ctrl  = r_alu_ctrl;
   assign out_valid = r_out_valid;
   assign out_y     = r_out_y;
   assign out_c     = r_out_c;
   assign out_err   = r_out_err;
   assign out_ctrl  = r_out_ctrl;
   assign busy      = (r_state != S_IDLE) || (r_count != '0);

`ifdef ALU_SEQ_STATS_EN
   logic [7:0] r_stat_ops;
   logic [7:0] r_stat_errs;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stat_ops  <= '0;
         r_stat_errs <= '0;
      end else if (r_out_valid && out_ready) begin
         if (r_stat_ops != 8'hFF) begin
            r_stat_ops <= r_stat_ops + 8'd1;
         end
         if (r_out_err && (r_stat_errs != 8'hFF)) begin
            r_stat_errs <= r_stat_errs + 8'd1;
         end
      end
   end

   assign stat_ops  = r_stat_ops;
   assign stat_errs = r_stat_errs;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: vector table plus scoreboard, with a
// behavioural multi-cycle ALU whose done latency is set per test.
module tb_alu_op_sequencer;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 15;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_a;
   logic [1:0] in_b;
   logic [1:0] in_ctrl;
   logic [1:0] alu_a;
   logic [1:0] alu_b;
   logic [1:0] alu_ctrl;
   logic       alu_start;
   logic [3:0] alu_y;
   logic       alu_c;
   logic       alu_done;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_y;
   logic       out_c;
   logic       out_err;
   logic [1:0] out_ctrl;
   logic       busy;
`ifdef ALU_SEQ_STATS_EN
   logic [7:0] stat_ops;
   logic [7:0] stat_errs;
`endif

   int n_pass    = 0;
   int n_total   = 0;
   int n_starts  = 0;
   int n_results = 0;
   int cyc       = 0;
   int alu_lat   = 3;   // 0 = ALU never asserts done
   int m_rem     = 0;
   logic [1:0] m_a, m_b, m_ctrl;
   logic [7:0] sb_q[$];
   logic [7:0] mon_got;
   logic [7:0] mon_exp;

   typedef struct {
      logic [1:0] a;
      logic [1:0] b;
      logic [1:0] ctrl;
      int         lat;
      logic [3:0] y;
      logic       c;
      logic       err;
      int         starts;
   } vec_t;

   vec_t vecs[9];
   vec_t fill[5];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_op_sequencer #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_ctrl   (in_ctrl),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_ctrl  (alu_ctrl),
      .alu_start (alu_start),
      .alu_y     (alu_y),
      .alu_c     (alu_c),
      .alu_done  (alu_done),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_c     (out_c),
      .out_err   (out_err),
      .out_ctrl  (out_ctrl),
      .busy      (busy)
`ifdef ALU_SEQ_STATS_EN
      ,
      .stat_ops  (stat_ops),
      .stat_errs (stat_errs)
`endif
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
   endtask

   task automatic fail(input string name, input string detail);
      n_total++;
      $display("FAIL %s: %s", name, detail);
   endtask

   // External ALU behaviour: returns {c, y}
   function automatic logic [4:0] alu_fn(input logic [1:0] a, input logic [1:0] b,
                                         input logic [1:0] ctrl);
      logic [3:0] ea, eb, y;
      logic       c;
      ea = {2'b00, a};
      eb = {2'b00, b};
      c  = 1'b0;
      case (ctrl)
         2'b00:   begin y = ea + eb; c = y[2]; end
         2'b01:   begin y = ea - eb; c = (a < b); end
         2'b10:   y = ea * eb;
         default: y = (b == 2'b00) ? 4'd0 : ea / eb;
      endcase
      return {c, y};
   endfunction

   // Model ALU: done is driven alu_lat cycles after the start cycle, for one cycle.
   initial begin
      alu_done = 1'b0;
      alu_y    = 4'd0;
      alu_c    = 1'b0;
      forever begin
         @(negedge clk);
         alu_done = 1'b0;
         alu_y    = 4'd0;
         alu_c    = 1'b0;
         if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
               alu_done       = 1'b1;
               {alu_c, alu_y} = alu_fn(m_a, m_b, m_ctrl);
            end
         end
         if (alu_start === 1'b1) begin
            n_starts++;
            m_a    = alu_a;
            m_b    = alu_b;
            m_ctrl = alu_ctrl;
            m_rem  = alu_lat;
            $display("issue %0d: a=%0d b=%0d ctrl=%0d", n_starts, alu_a, alu_b, alu_ctrl);
         end
      end
   end

   // Scoreboard consumer: compares every accepted result against the queue head.
   initial begin
      forever begin
         @(negedge clk);
         if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            mon_got = {out_y, out_c, out_err, out_ctrl};
            $display("result %0d: y=%0d c=%0d err=%0d ctrl=%0d",
                     n_results, out_y, out_c, out_err, out_ctrl);
            if (sb_q.size() == 0) begin
               fail("unexpected_result", $sformatf("got 0x%0h, expected no result", mon_got));
            end else begin
               mon_exp = sb_q.pop_front();
               check($sformatf("result_%0d", n_results), {24'd0, mon_got}, {24'd0, mon_exp});
            end
            n_results++;
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; leaves at posedge+1 after the push edge.
   task automatic push_op(input logic [1:0] a, input logic [1:0] b, input logic [1:0] ctrl,
                          input logic [7:0] exp);
      int n = 0;
      while (!in_ready && n < 200) begin
         sync();
         n++;
      end
      if (!in_ready) begin
         fail("push_wait", "in_ready stayed low for 200 cycles");
         return;
      end
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_ctrl  = ctrl;
      sb_q.push_back(exp);
      sync();
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((sb_q.size() != 0 || busy) && n < 400) begin
         sync();
         n++;
      end
      if (sb_q.size() != 0 || busy) fail(name, "results not drained within 400 cycles");
   endtask

   task automatic wait_start(output int t);
      t = -1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (alu_start === 1'b1) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) fail("start_seen", "alu_start not seen within 20 cycles");
   endtask

   function automatic logic [7:0] pack_exp(input vec_t v);
      return {v.y, v.c, v.err, v.ctrl};
   endfunction

   initial begin
      int s0, t0, t1;
      //          a     b     ctrl   lat  y      c     err   starts
      vecs[0] = '{2'd2, 2'd1, 2'b00, 3,  4'd3,  1'b0, 1'b0, 1};
      vecs[1] = '{2'd2, 2'd1, 2'b01, 3,  4'd1,  1'b0, 1'b0, 1};
      vecs[2] = '{2'd2, 2'd2, 2'b10, 3,  4'd4,  1'b0, 1'b0, 1};
      vecs[3] = '{2'd2, 2'd1, 2'b11, 3,  4'd2,  1'b0, 1'b0, 1};
      vecs[4] = '{2'd2, 2'd0, 2'b11, 3,  4'd0,  1'b0, 1'b1, 0};
      vecs[5] = '{2'd3, 2'd3, 2'b00, 1,  4'd6,  1'b1, 1'b0, 1};
      vecs[6] = '{2'd1, 2'd3, 2'b01, 15, 4'd14, 1'b1, 1'b0, 1};
      vecs[7] = '{2'd3, 2'd2, 2'b10, 0,  4'd0,  1'b0, 1'b1, 1};
      vecs[8] = '{2'd1, 2'd1, 2'b00, 2,  4'd2,  1'b0, 1'b0, 1};

      fill[0] = '{2'd0, 2'd1, 2'b00, 2, 4'd1, 1'b0, 1'b0, 1};
      fill[1] = '{2'd1, 2'd1, 2'b00, 2, 4'd2, 1'b0, 1'b0, 1};
      fill[2] = '{2'd1, 2'd2, 2'b00, 2, 4'd3, 1'b0, 1'b0, 1};
      fill[3] = '{2'd2, 2'd2, 2'b00, 2, 4'd4, 1'b1, 1'b0, 1};
      fill[4] = '{2'd3, 2'd1, 2'b01, 2, 4'd2, 1'b0, 1'b0, 1};

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_a      = 2'd0;
      in_b      = 2'd0;
      in_ctrl   = 2'd0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_out", {23'd0, out_valid, out_y, out_c, out_err, out_ctrl}, 32'd0);
      check("rst_alu", {25'd0, alu_start, alu_a, alu_b, alu_ctrl}, 32'd0);

      // Single ops, one at a time, covering every opcode, div-by-zero and timeout edges.
      for (int i = 0; i < 9; i++) begin
         sync();
         alu_lat = vecs[i].lat;
         s0 = n_starts;
         push_op(vecs[i].a, vecs[i].b, vecs[i].ctrl, pack_exp(vecs[i]));
         if (vecs[i].lat == 0) begin
            // ALU samples start one edge after it is first seen; the abort lands TIMEOUT edges later.
            wait_start(t0);
            t1 = -1;
            for (int n = 0; n < 40; n++) begin
               @(negedge clk);
               if (out_valid === 1'b1) begin
                  t1 = cyc;
                  break;
               end
            end
            if (t1 < 0) fail("timeout_seen", "out_valid not seen within 40 cycles");
            else check("timeout_latency", t1 - t0, TIMEOUT + 1);
         end
         wait_drain($sformatf("drain_v%0d", i));
         check($sformatf("starts_v%0d", i), n_starts - s0, vecs[i].starts);
      end

      // Back-to-back pushes, results in order.
      sync();
      alu_lat = 3;
      s0 = n_starts;
      for (int i = 1; i < 4; i++) push_op(vecs[i].a, vecs[i].b, vecs[i].ctrl, pack_exp(vecs[i]));
      wait_drain("drain_b2b");
      check("starts_b2b", n_starts - s0, 3);

      // Fill with the consumer stalled: FIFO full, result held stable, then drain all five.
      sync();
      out_ready = 1'b0;
      alu_lat   = 2;
      s0 = n_starts;
      for (int i = 0; i < 5; i++) push_op(fill[i].a, fill[i].b, fill[i].ctrl, pack_exp(fill[i]));
      repeat (8) sync();
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      check("full_busy", {31'd0, busy}, 32'd1);
      check("full_hold_a", {23'd0, out_valid, out_y, out_c, out_err, out_ctrl},
            {23'd0, 1'b1, pack_exp(fill[0])});
      in_valid = 1'b1;
      in_a     = 2'd3;
      in_b     = 2'd3;
      in_ctrl  = 2'b10;
      repeat (4) sync();
      in_valid = 1'b0;
      check("full_hold_b", {23'd0, out_valid, out_y, out_c, out_err, out_ctrl},
            {23'd0, 1'b1, pack_exp(fill[0])});
      check("full_starts", n_starts - s0, 1);
      out_ready = 1'b1;
      wait_drain("drain_fill");
      check("fill_starts", n_starts - s0, 5);

      // Reset while waiting on the ALU; the late done must be ignored.
      sync();
      alu_lat = 6;
      push_op(2'd1, 2'd2, 2'b10, 8'h00);
      wait_start(t0);
      repeat (3) sync();
      reset = 1'b1;
      #1;
      check("rstmid_flags", {28'd0, out_valid, alu_start, busy, in_ready}, 32'd1);
      check("rstmid_alu", {26'd0, alu_a, alu_b, alu_ctrl}, 32'd0);
      check("rstmid_res", {24'd0, out_y, out_c, out_err, out_ctrl}, 32'd0);
      sb_q.delete();
      sync();
      reset = 1'b0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         check($sformatf("late_done_%0d", n), {30'd0, out_valid, alu_start}, 32'd0);
      end
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      sync();
      alu_lat = 3;
      push_op(2'd3, 2'd1, 2'b00, {4'd4, 1'b1, 1'b0, 2'b00});
      wait_drain("drain_post_rst");

      check("sb_empty", sb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
